// File: rtl/seg_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-seg display sharing one decoder.
// Ports: clk, rst (async, high), en, load, value -> dec_code; dec_seg -> seg, digit_an, frame_done.
// Optional LEADING_ZERO_BLANK_EN: digits above the highest nonzero nibble stay dark.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              dec_code,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            frame_start;
  logic [VW-1:0]   pending, active;
  logic            digit_on;
  logic            show_n;
  logic [6:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic            fd_n;

  assign dec_code = active[4*idx +: 4];

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    frame_start = 1'b0;
    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n     = BLANK;
          cnt_n       = '0;
          idx_n       = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_DEAD) state_n = DRIVE;
        end
        DRIVE: begin
          if (cnt == CNT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n       = '0;
              frame_start = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] top;
  always_comb begin
    top = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (active[4*k +: 4] != 4'h0) top = IW'(k);
    digit_on = (idx_n <= top);
  end
`else
  assign digit_on = 1'b1;
`endif

  // Outputs are registered from the next state so anode, segments
  // and frame_done all line up with the slot the FSM is in.
  // active is stable whenever state_n is DRIVE, so digit_on is valid.
  always_comb begin
    show_n = (state_n == DRIVE) && digit_on;
    seg_n  = show_n ? dec_seg : 7'h7F;
    for (int k = 0; k < NUM_DIGITS; k++)
      an_n[k] = !(show_n && (idx_n == IW'(k)));
    fd_n = (state_n == DRIVE) && (idx_n == IDX_LAST)
        && (cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      seg        <= 7'h7F;
      digit_an   <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      seg        <= seg_n;
      digit_an   <= an_n;
      frame_done <= fd_n;
      if (load) pending <= value;
      if (frame_start) active <= load ? value : pending;
    end
  end

endmodule
